// File: rtl/nbit_serial_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the bit-serial subtractor:
//   state_t    - controller states (IDLE, SHIFT, DONE)
//   cnt_width  - width of the bit counter, clog2(width+1), so the counter can
//                represent every value from 0 up to width without wrapping
// ----------------------------------------------------------------------------
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// ----------------------------------------------------------------------------
// full_subtractor_1bit
// Purely combinational one-bit full subtractor: x - y - bi.
// Ports:
//   x   in   minuend bit
//   y   in   subtrahend bit
//   bi  in   borrow-in
//   d   out  difference bit
//   bo  out  borrow-out
// A half subtractor is obtained by tying bi to 0.
// ----------------------------------------------------------------------------
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    // Borrow when x < y, or when x == y and a borrow is already pending.
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/nbit_serial_subtractor.sv
// ----------------------------------------------------------------------------
// nbit_serial_subtractor
// Bit-serial subtractor computing {bout, diff} = a - b - bin, LSB first,
// reusing one full-subtractor cell over WIDTH cycles.
// Parameters:
//   WIDTH                operand/result width (2..32)
//   USE_FULL_SUBTRACTOR  1: bin seeds the borrow; 0: bin ignored, borrow starts at 0
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   start  in   request pulse, only sampled in IDLE
//   a, b   in   minuend / subtrahend, captured on an accepted start
//   bin    in   borrow-in, captured on an accepted start
//   diff   out  registered difference, held until the next completion
//   bout   out  registered borrow-out, held until the next completion
//   busy   out  high while bits are being processed
//   done   out  one-cycle completion pulse
// ----------------------------------------------------------------------------
module nbit_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH               = 4,
    parameter bit USE_FULL_SUBTRACTOR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic             brw_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] res_next;

    full_subtractor_1bit u_cell (
        .x  (a_sh_reg[0]),
        .y  (b_sh_reg[0]),
        .bi (brw_reg),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // The newest bit enters at the MSB, so after WIDTH shifts the LSB
    // computed first has reached bit 0.
    assign res_next = {cell_d, res_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            brw_reg   <= 1'b0;
            cnt_reg   <= '0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        brw_reg   <= bin & USE_FULL_SUBTRACTOR;
                        res_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh_reg <= a_sh_reg >> 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    res_reg  <= res_next;
                    brw_reg  <= cell_bo;
                    cnt_reg  <= cnt_reg + CW'(1);
                    // Outputs only update here, so the previous result stays
                    // visible for the whole SHIFT phase.
                    if (cnt_reg == LAST_BIT) begin
                        diff_reg  <= res_next;
                        bout_reg  <= cell_bo;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule
